// File: rtl/fault_pkg.sv
// Shared severity encoding and defaults for the fault classifier.
package fault_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MINOR    = 2'b01,
    FAULT_CRITICAL = 2'b10,
    FAULT_MAJOR    = 2'b11
  } fault_e;

  localparam int DEFAULT_CNT_W = 8;

  // Stuck-at dominates everything; two simultaneous minor sources escalate to MAJOR.
  function automatic fault_e classify(input logic illegal_opcode,
                                      input logic invalid_control,
                                      input logic stuck_at_fault);
    fault_e sev;
    if (stuck_at_fault) begin
      sev = FAULT_CRITICAL;
    end else if (illegal_opcode && invalid_control) begin
      sev = FAULT_MAJOR;
    end else if (illegal_opcode || invalid_control) begin
      sev = FAULT_MINOR;
    end else begin
      sev = FAULT_NONE;
    end
    return sev;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Parameterised saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != MAX_VAL)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fault_classifier.sv
// Registered fault severity classifier with sticky critical latch and halt request.
// Event counters are built only when FAULT_CLASSIFIER_COUNTERS_EN is defined.
module fault_classifier
  import fault_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             illegal_opcode,
  input  logic             invalid_control,
  input  logic             stuck_at_fault,
  input  logic             fault_clear,
  output logic [1:0]       fault_type,
  output logic             fault_valid,
  output logic             critical_latched,
  output logic             halt_req,
  output logic [CNT_W-1:0] minor_count,
  output logic [CNT_W-1:0] critical_count
);

  fault_e sev_now;

  fault_e fault_type_q;
  fault_e fault_type_d;
  logic   fault_valid_q;
  logic   fault_valid_d;
  logic   critical_q;
  logic   critical_d;

  // A set in the same cycle as a clear must win, so the set term is checked first.
  always_comb begin
    sev_now       = classify(illegal_opcode, invalid_control, stuck_at_fault);
    fault_type_d  = sev_now;
    fault_valid_d = (sev_now != FAULT_NONE);
    critical_d    = critical_q;
    if (sev_now == FAULT_CRITICAL) begin
      critical_d = 1'b1;
    end else if (fault_clear) begin
      critical_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_type_q  <= FAULT_NONE;
      fault_valid_q <= 1'b0;
      critical_q    <= 1'b0;
    end else begin
      fault_type_q  <= fault_type_d;
      fault_valid_q <= fault_valid_d;
      critical_q    <= critical_d;
    end
  end

  assign fault_type       = fault_type_q;
  assign fault_valid      = fault_valid_q;
  assign critical_latched = critical_q;
  assign halt_req         = critical_q;

`ifdef FAULT_CLASSIFIER_COUNTERS_EN
  logic minor_inc;
  logic critical_inc;

  always_comb begin
    minor_inc    = (sev_now == FAULT_MINOR) || (sev_now == FAULT_MAJOR);
    critical_inc = (sev_now == FAULT_CRITICAL);
  end

  sat_counter #(.W(CNT_W)) u_minor_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (minor_inc),
    .count (minor_count)
  );

  sat_counter #(.W(CNT_W)) u_critical_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (critical_inc),
    .count (critical_count)
  );
`else
  assign minor_count    = '0;
  assign critical_count = '0;
`endif

endmodule

// File: tb/tb_fault_classifier.sv
// Randomised and directed self-checking bench for fault_classifier (CNT_W=8 and CNT_W=3 instances).
module tb_fault_classifier;

`ifdef FAULT_CLASSIFIER_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic illegal_opcode;
  logic invalid_control;
  logic stuck_at_fault;
  logic fault_clear;

  logic [1:0] fault_type_a, fault_type_b;
  logic       fault_valid_a, fault_valid_b;
  logic       critical_latched_a, critical_latched_b;
  logic       halt_req_a, halt_req_b;
  logic [7:0] minor_count_a, critical_count_a;
  logic [2:0] minor_count_b, critical_count_b;

  int checks;
  int errors;

  // Reference model state
  int exp_type;
  int exp_crit;
  int exp_minor_a, exp_critc_a;
  int exp_minor_b, exp_critc_b;

  fault_classifier #(.CNT_W(8)) dut_a (
    .clk              (clk),
    .rst              (rst),
    .illegal_opcode   (illegal_opcode),
    .invalid_control  (invalid_control),
    .stuck_at_fault   (stuck_at_fault),
    .fault_clear      (fault_clear),
    .fault_type       (fault_type_a),
    .fault_valid      (fault_valid_a),
    .critical_latched (critical_latched_a),
    .halt_req         (halt_req_a),
    .minor_count      (minor_count_a),
    .critical_count   (critical_count_a)
  );

  fault_classifier #(.CNT_W(3)) dut_b (
    .clk              (clk),
    .rst              (rst),
    .illegal_opcode   (illegal_opcode),
    .invalid_control  (invalid_control),
    .stuck_at_fault   (stuck_at_fault),
    .fault_clear      (fault_clear),
    .fault_type       (fault_type_b),
    .fault_valid      (fault_valid_b),
    .critical_latched (critical_latched_b),
    .halt_req         (halt_req_b),
    .minor_count      (minor_count_b),
    .critical_count   (critical_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int sat_add(input int val, input int maxv);
    return (val >= maxv) ? maxv : val + 1;
  endfunction

  // Model update from the severity rules: priority class, sticky latch, saturating counts.
  task automatic modelStep();
    int sev;
    if (rst) begin
      exp_type = 0; exp_crit = 0;
      exp_minor_a = 0; exp_critc_a = 0; exp_minor_b = 0; exp_critc_b = 0;
    end else begin
      if (stuck_at_fault) sev = 2;
      else if (illegal_opcode && invalid_control) sev = 3;
      else if (illegal_opcode || invalid_control) sev = 1;
      else sev = 0;
      exp_type = sev;
      if (sev == 2) exp_crit = 1;
      else if (fault_clear) exp_crit = 0;
      if (CNT_EN) begin
        if (sev == 1 || sev == 3) begin
          exp_minor_a = sat_add(exp_minor_a, 255);
          exp_minor_b = sat_add(exp_minor_b, 7);
        end
        if (sev == 2) begin
          exp_critc_a = sat_add(exp_critc_a, 255);
          exp_critc_b = sat_add(exp_critc_b, 7);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic io, input logic ic,
                               input logic sa, input logic fc);
    rst = r; illegal_opcode = io; invalid_control = ic;
    stuck_at_fault = sa; fault_clear = fc;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput("type_a",  int'(fault_type_a), exp_type);
    checkOutput("valid_a", int'(fault_valid_a), (exp_type != 0) ? 1 : 0);
    checkOutput("crit_a",  int'(critical_latched_a), exp_crit);
    checkOutput("halt_a",  int'(halt_req_a), exp_crit);
    checkOutput("minor_a", int'(minor_count_a), exp_minor_a);
    checkOutput("critc_a", int'(critical_count_a), exp_critc_a);
    checkOutput("type_b",  int'(fault_type_b), exp_type);
    checkOutput("crit_b",  int'(critical_latched_b), exp_crit);
    checkOutput("minor_b", int'(minor_count_b), exp_minor_b);
    checkOutput("critc_b", int'(critical_count_b), exp_critc_b);
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_type = 0; exp_crit = 0;
    exp_minor_a = 0; exp_critc_a = 0; exp_minor_b = 0; exp_critc_b = 0;
    rst = 1'b1; illegal_opcode = 1'b0; invalid_control = 1'b0;
    stuck_at_fault = 1'b0; fault_clear = 1'b0;
    @(negedge clk);

    // Reset held with every fault input active, then released with stuck-at still high
    applyStimulus(1, 1, 1, 1, 0);
    applyStimulus(1, 1, 1, 1, 0);
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("rel_type", int'(fault_type_a), 2);
    checkOutput("rel_crit", int'(critical_latched_a), 1);

    // Clean up and reset again before the minor-source scenario
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("minor1_type", int'(fault_type_a), 1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("minor2_type", int'(fault_type_a), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("idle_type", int'(fault_type_a), 0);
    checkOutput("minor_cnt2", int'(minor_count_a), CNT_EN ? 2 : 0);
    checkOutput("minor_nolatch", int'(critical_latched_a), 0);

    // Priority: MAJOR, then stuck-at overrides to CRITICAL
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("major_type", int'(fault_type_a), 3);
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("prio_type", int'(fault_type_a), 2);
    checkOutput("prio_critc", int'(critical_count_a), CNT_EN ? 1 : 0);

    // Latch persists after the fault drops, clears on fault_clear, set beats clear
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("sticky_halt", int'(halt_req_a), 1);
    checkOutput("sticky_type", int'(fault_type_a), 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("clear_crit", int'(critical_latched_a), 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("setwins_crit", int'(critical_latched_a), 1);
    applyStimulus(0, 0, 0, 0, 0);

    // Saturation on the 3-bit instance
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 0);
    checkOutput("sat_minor_b", int'(minor_count_b), CNT_EN ? 7 : 0);

    // Mid-fault reset clears everything on that edge
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("midrst_crit", int'(critical_latched_a), 0);

    // Randomised traffic; stuck-at is kept rare so the latch gets cleared regularly
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 35),
                    ($urandom_range(0, 99) < 35),
                    ($urandom_range(0, 99) < 8),
                    ($urandom_range(0, 99) < 25));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
